srl_iter: RTL and testbench
===========================

# srl_iter

Iterative 16-bit right-shift/rotate unit for the execute stage: it is the right-direction counterpart to the single-step left-shift stages already in the datapath. A request captures a 16-bit operand, a 4-bit shift count and a 2-bit mode. The block applies one binary-weighted stage (8, 4, 2, then 1) per clock. The result appears in a holding register with a one-cycle `done` pulse. Fixed latency keeps pipeline stall logic trivial.

## Interface
Parameters:
- none (data width fixed at 16, count width fixed at 4)

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: request strobe; sampled on rising edge
- `in` in 16: operand, captured when a request is accepted
- `cnt` in 4: shift amount 0–15, captured when a request is accepted
- `mode` in 2: 00 logical right, 01 arithmetic right, 10 rotate right, 11 behaves as 00; captured when a request is accepted
- `out` out 16: result register; holds the last completed result
- `busy` out 1: high while in SHIFT
- `done` out 1: high for exactly one cycle when `out` is updated

## Operation
- States: IDLE, SHIFT, DONE. Encode in registered state bits. `busy` = (state==SHIFT). `done` = (state==DONE).
- Request acceptance:
  - A request is accepted when `start`=1 at a rising edge with state IDLE or DONE.
  - On acceptance: working reg ← `in`; cnt_r ← `cnt`; mode_r ← `mode`; stage index k ← 3; state ← SHIFT.
- SHIFT, each rising edge:
  - If cnt_r[k]=1, the working reg is shifted right by 2^k per mode_r. Otherwise it is unchanged.
  - k decrements.
  - When k=0 is processed, `out` ← the final working value and state ← DONE.
- Fill rules:
  - Logical: zeros fill the vacated MSBs.
  - Arithmetic: copies of bit 15 of the current working value fill the vacated MSBs.
  - Rotate: bits leaving LSB re-enter at MSB.
- Results:
  - Result equals the single-cycle reference: logical `in >> cnt`, arithmetic signed `in >>> cnt`, rotate `(in >> cnt) | (in << (16-cnt))`.
  - `cnt`=0 yields `in` unchanged.
- DONE: if `start`=1 at the next edge, the new request is accepted (back-to-back). Otherwise state ← IDLE.
- `start` in SHIFT is ignored. No queueing, no error indication.
- `in`/`cnt`/`mode` are don't-care except at the accepting edge.
- `out` changes only on the SHIFT→DONE edge or reset.

## Timing
- Reset:
  - Asserting `rst` immediately forces state IDLE, `out`=0x0000, `busy`=0, `done`=0, working reg=0, k=0.
  - Reset mid-operation aborts the operation; no `done` is produced.
- Latency:
  - Accepting edge E0. SHIFT at edges E1..E4 (k=3,2,1,0). `busy` high after E0 through E4.
  - `out` valid and `done`=1 in the cycle after E4.
  - Latency is 4 cycles regardless of `cnt`.
- Throughput: one request per 5 cycles, sustained by asserting `start` during DONE.
- `start` held high continuously gives back-to-back requests: a request is accepted in IDLE or DONE, and `start` is ignored while `busy`.
- Deassertion of `rst` is synchronous to `clk` externally; the block makes no internal synchronizer assumption.

## Test plan
- Logical: `in`=0x8000, `cnt`=4, `mode`=00 → `done` one cycle after 4th SHIFT edge, `out`=0x0800, `busy` high exactly 4 cycles.
- Arithmetic and edge counts: `in`=0x8000, `cnt`=15, `mode`=01 → `out`=0xFFFF. Repeat with `in`=0x7FF0, `cnt`=4 → 0x07FF. `mode`=11 with 0x8000, cnt 4 → 0x0800.
- Rotate: `in`=0x1234, `cnt`=4, `mode`=10 → `out`=0x4123. `cnt`=0 → `out`=0x1234 after the full 4-cycle latency.
- Handshake: during SHIFT pulse `start` with `in`=0xFFFF → ignored, original result delivered. Hold `start` high in DONE with new request 0x00F0 cnt 4 logical → accepted, next `done` yields 0x000F five cycles later.
- Reset: assert `rst` during 2nd SHIFT cycle → `busy`=0, `done`=0, `out`=0x0000 immediately. No `done` follows. A fresh request afterward completes normally.
- Random: ≥1000 random `in`/`cnt`/`mode` requests compared against the single-cycle reference formulas. Check latency and the one-cycle `done` width on every request.

Source files
------------

// File: rtl/srl_iter.sv
// Iterative 16-bit right shift/rotate: one binary-weighted stage (8, 4, 2, 1) per clock.
// A result register holds the last completed result, and a one-cycle done pulse marks each update.
module srl_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [3:0]  cnt,
    input  logic [1:0]  mode,
    output logic [15:0] out,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_work;
    logic [3:0]  r_cnt;
    logic [1:0]  r_mode;
    logic [1:0]  r_k;
    logic [15:0] r_out;

    logic [15:0] w_lsr;
    logic [15:0] w_asr;
    logic [15:0] w_ror;
    logic [15:0] w_step;
    logic [15:0] w_next;
    logic        w_accept;

    // Candidate results for a shift of 2^k in each fill style.
    always_comb begin
        w_lsr = r_work;
        w_asr = r_work;
        w_ror = r_work;
        case (r_k)
            2'd3: begin
                w_lsr = {8'h00, r_work[15:8]};
                w_asr = {{8{r_work[15]}}, r_work[15:8]};
                w_ror = {r_work[7:0], r_work[15:8]};
            end
            2'd2: begin
                w_lsr = {4'h0, r_work[15:4]};
                w_asr = {{4{r_work[15]}}, r_work[15:4]};
                w_ror = {r_work[3:0], r_work[15:4]};
            end
            2'd1: begin
                w_lsr = {2'b00, r_work[15:2]};
                w_asr = {{2{r_work[15]}}, r_work[15:2]};
                w_ror = {r_work[1:0], r_work[15:2]};
            end
            default: begin
                w_lsr = {1'b0, r_work[15:1]};
                w_asr = {r_work[15], r_work[15:1]};
                w_ror = {r_work[0], r_work[15:1]};
            end
        endcase
    end

    always_comb begin
        case (r_mode)
            2'b01:   w_step = w_asr;
            2'b10:   w_step = w_ror;
            default: w_step = w_lsr;
        endcase
        w_next = r_cnt[r_k] ? w_step : r_work;
    end

    // start is only honoured when no operation is in flight.
    assign w_accept = start && (r_state != S_SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= 16'h0000;
            r_cnt   <= 4'h0;
            r_mode  <= 2'b00;
            r_k     <= 2'd0;
            r_out   <= 16'h0000;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_work <= w_next;
                    if (r_k == 2'd0) begin
                        r_out   <= w_next;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k - 2'd1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_work  <= in;
                        r_cnt   <= cnt;
                        r_mode  <= mode;
                        r_k     <= 2'd3;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign out       = r_out;
    assign busy      = (r_state == S_SHIFT);
    assign done      = (r_state == S_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_srl_iter.sv
// Directed and random checks of srl_iter: results, 4-cycle latency, done width, handshake, reset abort.
module tb_srl_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_v;
    logic [3:0]  cnt_v;
    logic [1:0]  mode_v;
    logic [15:0] out_v;
    logic        busy_v;
    logic        done_v;
    logic [1:0]  dbg_state_v;

    int checks;
    int errors;

    srl_iter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in        (in_v),
        .cnt       (cnt_v),
        .mode      (mode_v),
        .out       (out_v),
        .busy      (busy_v),
        .done      (done_v),
        .dbg_state (dbg_state_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_model(input logic [15:0] a, input logic [3:0] c,
                                              input logic [1:0] m);
        logic [31:0] dbl;
        logic [15:0] r;
        dbl = {a, a} >> c;
        case (m)
            2'b01:   r = 16'($signed(a) >>> c);
            2'b10:   r = dbl[15:0];
            default: r = a >> c;
        endcase
        return r;
    endfunction

    // Issue one request from IDLE, then check latency, busy width, result and done width.
    task automatic run_req(input logic [15:0] a, input logic [3:0] c, input logic [1:0] m,
                           input logic [15:0] exp, input string name);
        int busy_n;
        int lat;
        bit got;
        @(negedge clk);
        start = 1'b1; in_v = a; cnt_v = c; mode_v = m;
        @(negedge clk);
        start = 1'b0; in_v = 16'($urandom); cnt_v = 4'($urandom); mode_v = 2'($urandom);
        busy_n = 0; lat = 0; got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done_v) begin
                got = 1'b1;
                lat = i;
                break;
            end
            if (busy_v) busy_n++;
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: done never seen, required within 10 cycles", name);
        end else begin
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL %s latency: got %0d required 4", name, lat);
            end
            checks++;
            if (busy_n !== 4) begin
                errors++;
                $display("FAIL %s busy_cycles: got %0d required 4", name, busy_n);
            end
            checks++;
            if (out_v !== exp) begin
                errors++;
                $display("FAIL %s out: got %h required %h (in=%h cnt=%0d mode=%b)",
                         name, out_v, exp, a, c, m);
            end
            @(negedge clk);
            checks++;
            if (done_v !== 1'b0 || busy_v !== 1'b0) begin
                errors++;
                $display("FAIL %s done_width: done=%b busy=%b required 0 0", name, done_v, busy_v);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_v = 16'h0; cnt_v = 4'h0; mode_v = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (out_v !== 16'h0000 || busy_v !== 1'b0 || done_v !== 1'b0 || dbg_state_v !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: out=%h busy=%b done=%b state=%0d required 0000 0 0 0",
                     out_v, busy_v, done_v, dbg_state_v);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_v !== 1'b0 || done_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy=%b done=%b required 0 0", busy_v, done_v);
        end
    endtask

    task automatic test_logical();
        run_req(16'h8000, 4'd4, 2'b00, 16'h0800, "lsr_8000_4");
        run_req(16'hABCD, 4'd15, 2'b00, 16'h0001, "lsr_abcd_15");
        run_req(16'h8000, 4'd4, 2'b11, 16'h0800, "mode11_8000_4");
    endtask

    task automatic test_arith();
        run_req(16'h8000, 4'd15, 2'b01, 16'hFFFF, "asr_8000_15");
        run_req(16'h7FF0, 4'd4, 2'b01, 16'h07FF, "asr_7ff0_4");
        run_req(16'hF00F, 4'd0, 2'b01, 16'hF00F, "asr_cnt0");
    endtask

    task automatic test_rotate();
        run_req(16'h1234, 4'd4, 2'b10, 16'h4123, "ror_1234_4");
        run_req(16'h1234, 4'd0, 2'b10, 16'h1234, "ror_cnt0");
        run_req(16'h0001, 4'd15, 2'b10, 16'h0002, "ror_0001_15");
    endtask

    task automatic test_back_to_back();
        bit got;
        int gap;
        @(negedge clk);
        start = 1'b1; in_v = 16'h1234; cnt_v = 4'd4; mode_v = 2'b10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; in_v = 16'hFFFF; cnt_v = 4'd0; mode_v = 2'b00;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done_v) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got || out_v !== 16'h4123) begin
            errors++;
            $display("FAIL b2b_ignore_in_shift: done=%b out=%h required 1 4123", got, out_v);
        end
        start = 1'b1; in_v = 16'h00F0; cnt_v = 4'd4; mode_v = 2'b00;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy_v !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_in_done: busy=%b required 1", busy_v);
        end
        got = 1'b0; gap = 1;
        for (int i = 0; i < 10; i++) begin
            if (done_v) begin got = 1'b1; break; end
            gap++;
            @(negedge clk);
        end
        checks++;
        if (!got || gap !== 5 || out_v !== 16'h000F) begin
            errors++;
            $display("FAIL b2b_second: seen=%b gap=%0d out=%h required 1 5 000F", got, gap, out_v);
        end
        // start held high: done should pulse every 5 cycles
        start = 1'b1; in_v = 16'h8000; cnt_v = 4'd1; mode_v = 2'b01;
        @(negedge clk);
        got = 1'b0; gap = 1;
        for (int i = 0; i < 10; i++) begin
            if (done_v) begin got = 1'b1; break; end
            gap++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (!got || gap !== 5 || out_v !== 16'hC000) begin
            errors++;
            $display("FAIL b2b_held_start: seen=%b gap=%0d out=%h required 1 5 C000", got, gap, out_v);
        end
        repeat (2) @(negedge clk);
        // the held start may have accepted one more request; let it drain
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit seen;
        @(negedge clk);
        start = 1'b1; in_v = 16'h8000; cnt_v = 4'd4; mode_v = 2'b00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy_v !== 1'b0 || done_v !== 1'b0 || out_v !== 16'h0000) begin
            errors++;
            $display("FAIL reset_abort: busy=%b done=%b out=%h required 0 0 0000", busy_v, done_v, out_v);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_v || busy_v) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_done: activity seen after abort, required none");
        end
        run_req(16'h00F0, 4'd4, 2'b00, 16'h000F, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [3:0]  c;
        logic [1:0]  m;
        for (int n = 0; n < 1000; n++) begin
            a = 16'($urandom);
            c = 4'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 3));
            run_req(a, c, m, ref_model(a, c, m), "random");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_logical();
        test_arith();
        test_rotate();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
